fill_counter: RTL and testbench

//  Counting stage between the hopper pill sensor and the bottling controller FSM.
//  - Conditions the raw hopper pulse: 2-flop sync, debounce, rising-edge strobe.
//  - Keeps BCD pill-per-bottle and bottle-per-batch counts, and raises bottle_full / batch_done.
//  - Raises starve when no pill arrives within a timeout.
//  The controller consumes these flags instead of doing its own counting.

---
 rtl/fill_counter_pkg.sv | 66 ++++++
 rtl/fill_counter_if.sv | 34 +++
 rtl/fill_counter_pulse_debounce.sv | 56 +++++
 rtl/fill_counter.sv | 126 ++++++++++++
 tb/tb_fill_counter.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fill_counter_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fill_pkg
//  Description : Shared types, default timing constants and BCD helpers for
//                the fill_counter slice.
//  Revision    : 1.0  initial release
// ============================================================================
package fill_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int c_DEB_MS    = 5;
    localparam int c_STARVE_MS = 5000;

    // Three-digit BCD increment; 999 holds.
    function automatic logic [11:0] bcd_inc3(input logic [11:0] v);
        bcd_digit_t d0, d1, d2;
        logic [11:0] r;
        {d2, d1, d0} = v;
        if (v == 12'h999) begin
            r = v;
        end else begin
            if (d0 != 4'd9) begin
                d0 = d0 + 4'd1;
            end else begin
                d0 = 4'd0;
                if (d1 != 4'd9) begin
                    d1 = d1 + 4'd1;
                end else begin
                    d1 = 4'd0;
                    d2 = d2 + 4'd1;
                end
            end
            r = {d2, d1, d0};
        end
        return r;
    endfunction

    // Two-digit BCD increment; 99 holds.
    function automatic logic [7:0] bcd_inc2(input logic [7:0] v);
        bcd_digit_t d0, d1;
        logic [7:0] r;
        {d1, d0} = v;
        if (v == 8'h99) begin
            r = v;
        end else begin
            if (d0 != 4'd9) begin
                d0 = d0 + 4'd1;
            end else begin
                d0 = 4'd0;
                d1 = d1 + 4'd1;
            end
            r = {d1, d0};
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fill_counter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : fill_counter_if
//  Description : Sensor, controller and count/flag signals between the
//                bottling controller (master) and fill_counter (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface fill_counter_if;
    logic        pill_raw;
    logic        enable;
    logic        bottle_advance;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic        pill_strobe;
    logic        bottle_full;
    logic        batch_done;
    logic        starve;
    logic        overfill;

    modport master (
        output pill_raw, enable, bottle_advance, target_pills, target_bottles,
        input  now_pills, now_bottles, pill_strobe, bottle_full, batch_done,
               starve, overfill
    );

    modport slave (
        input  pill_raw, enable, bottle_advance, target_pills, target_bottles,
        output now_pills, now_bottles, pill_strobe, bottle_full, batch_done,
               starve, overfill
    );
endinterface
`default_nettype wire

// File: rtl/fill_counter_pulse_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_debounce
//  Description : 2-flop synchroniser, DEB_MS-sample stability filter and a
//                registered one-cycle strobe on each accepted rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module pulse_debounce
    import fill_pkg::*;
#(
    parameter int DEB_MS = c_DEB_MS
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw,
    output logic      o_rise
);

    localparam int c_CW = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;

    logic            r_s1;
    logic            r_s2;
    logic            r_level;
    logic            r_level_d;
    logic            r_rise;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1      <= 1'b0;
            r_s2      <= 1'b0;
            r_level   <= 1'b0;
            r_level_d <= 1'b0;
            r_rise    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_s1      <= i_raw;
            r_s2      <= r_s1;
            r_level_d <= r_level;
            r_rise    <= r_level & ~r_level_d;
            // Any sample that agrees with the accepted level restarts the run.
            if (r_s2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CW'(DEB_MS - 1)) begin
                r_level <= r_s2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/fill_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fill_counter
//  Description : Pill/bottle BCD counting stage with starvation timeout.
//                Optional overfill detect: FILL_COUNTER_OVERFILL_DET_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module fill_counter
    import fill_pkg::*;
#(
    parameter int DEB_MS    = c_DEB_MS,
    parameter int STARVE_MS = c_STARVE_MS,
    parameter int TW        = 13
) (
    input  wire logic     clk_1khz,
    input  wire logic     clr,
    fill_counter_if.slave bus
);

    localparam logic [TW-1:0] c_STARVE = TW'(STARVE_MS);

    fill_state_t   r_state;
    fill_state_t   w_state_nx;
    logic [11:0]   r_pills;
    logic [11:0]   w_pills_nx;
    logic [7:0]    r_bottles;
    logic [7:0]    w_bottles_nx;
    logic [7:0]    w_bottles_inc;
    logic [TW-1:0] r_timer;
    logic [TW-1:0] w_timer_nx;
    logic          w_strobe;

    pulse_debounce #(
        .DEB_MS (DEB_MS)
    ) u_deb (
        .clk    (clk_1khz),
        .rst    (clr),
        .i_raw  (bus.pill_raw),
        .o_rise (w_strobe)
    );

    assign w_bottles_inc = bcd_inc2(r_bottles);

    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            r_state   <= IDLE;
            r_pills   <= '0;
            r_bottles <= '0;
            r_timer   <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_pills   <= w_pills_nx;
            r_bottles <= w_bottles_nx;
            r_timer   <= w_timer_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_pills_nx   = r_pills;
        w_bottles_nx = r_bottles;
        case (r_state)
            IDLE: begin
                if (bus.enable) w_state_nx = FILLING;
            end
            FILLING: begin
                // Target match wins over a coincident pill, which is dropped.
                if (bus.enable) begin
                    if (r_pills == bus.target_pills) begin
                        w_bottles_nx = w_bottles_inc;
                        w_state_nx   = (w_bottles_inc == bus.target_bottles) ? DONE : FULL;
                    end else if (w_strobe) begin
                        w_pills_nx = bcd_inc3(r_pills);
                    end
                end
            end
            FULL: begin
                if (bus.bottle_advance) begin
                    w_pills_nx = '0;
                    w_state_nx = FILLING;
                end
            end
            DONE: begin
                w_state_nx = DONE;
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        w_timer_nx = r_timer;
        if (w_strobe || bus.bottle_advance) begin
            w_timer_nx = '0;
        end else if ((r_state == FILLING) && bus.enable && (r_timer != c_STARVE)) begin
            w_timer_nx = r_timer + 1'b1;
        end
    end

`ifdef FILL_COUNTER_OVERFILL_DET_EN
    logic r_overfill;

    always_ff @(posedge clk_1khz) begin
        if (clr) begin
            r_overfill <= 1'b0;
        end else if (w_strobe && (((r_state == FULL) && !bus.bottle_advance) ||
                                  (r_state == DONE))) begin
            r_overfill <= 1'b1;
        end
    end

    assign bus.overfill = r_overfill;
`else
    assign bus.overfill = 1'b0;
`endif

    assign bus.now_pills   = r_pills;
    assign bus.now_bottles = r_bottles;
    assign bus.pill_strobe = w_strobe;
    assign bus.bottle_full = (r_state == FULL) || (r_state == DONE);
    assign bus.batch_done  = (r_state == DONE);
    assign bus.starve      = (r_timer == c_STARVE);

endmodule
`default_nettype wire

// File: tb/tb_fill_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fill_counter
//  Description : Self-checking bench for fill_counter against a decimal
//                event-level reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fill_counter;

    localparam int D   = 5;
    localparam int SMS = 300;
    localparam int M_IDLE = 0, M_FILL = 1, M_FULL = 2, M_DONE = 3;
`ifdef FILL_COUNTER_OVERFILL_DET_EN
    localparam bit OVF = 1'b1;
`else
    localparam bit OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    fill_counter_if bus ();

    fill_counter #(
        .DEB_MS    (D),
        .STARVE_MS (SMS),
        .TW        (9)
    ) dut (
        .clk_1khz (clk),
        .clr      (clr),
        .bus      (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int exp_q[$];
    int m_st, m_p, m_b, m_t;
    bit m_over;

    function automatic int dec3(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int dec2(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [11:0] bcd3(input int n);
        return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [7:0] bcd2(input int n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dut_outs();
        return {7'd0, bus.now_pills, bus.now_bottles, bus.pill_strobe,
                bus.bottle_full, bus.batch_done, bus.starve, bus.overfill};
    endfunction

    function automatic logic [31:0] exp_outs();
        logic st;
        st = (exp_q.size() > 0) && (exp_q[0] == cyc);
        return {7'd0, bcd3(m_p), bcd2(m_b), st,
                (m_st == M_FULL) || (m_st == M_DONE), m_st == M_DONE,
                m_t == SMS, OVF && m_over};
    endfunction

    // Reference behaviour at one clock edge, in decimal counts.
    task automatic model_edge();
        bit st;
        int tp, tb;
        st = (exp_q.size() > 0) && (exp_q[0] == cyc);
        if (st) void'(exp_q.pop_front());
        tp = dec3(bus.target_pills);
        tb = dec2(bus.target_bottles);
        if (clr) begin
            m_st = M_IDLE; m_p = 0; m_b = 0; m_t = 0; m_over = 0;
            exp_q.delete();
        end else begin
            if (st || bus.bottle_advance) m_t = 0;
            else if (m_st == M_FILL && bus.enable && m_t < SMS) m_t++;
            case (m_st)
                M_IDLE: if (bus.enable) m_st = M_FILL;
                M_FILL: if (bus.enable) begin
                    if (m_p == tp) begin
                        m_b  = (m_b < 99) ? m_b + 1 : 99;
                        m_st = (m_b == tb) ? M_DONE : M_FULL;
                    end else if (st) begin
                        m_p = (m_p < 999) ? m_p + 1 : 999;
                    end
                end
                M_FULL: begin
                    if (bus.bottle_advance) begin
                        m_p = 0; m_st = M_FILL;
                    end else if (st) begin
                        m_over = 1;
                    end
                end
                default: if (st) m_over = 1;
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        chk("outs", dut_outs(), exp_outs());
    endtask

    // Raw pulse of width w followed by gap low cycles; optional coincident advance.
    task automatic pill(input int w, input int gap, input bit adv_hit,
                        output int n_str, output int lat);
        int r;
        r = cyc;
        if (w >= D) exp_q.push_back(r + D + 3);
        n_str = 0;
        lat   = -1;
        for (int i = 0; i < w + gap; i++) begin
            bus.pill_raw       = (i < w);
            bus.bottle_advance = adv_hit && (i == D + 3);
            step();
            if (bus.pill_strobe) begin
                n_str++;
                if (lat < 0) lat = i + 1;
            end
        end
        bus.pill_raw       = 1'b0;
        bus.bottle_advance = 1'b0;
    endtask

    task automatic pp();
        int ns, lt;
        pill(D + 2, D + 2, 1'b0, ns, lt);
    endtask

    task automatic advance();
        bus.bottle_advance = 1'b1;
        step();
        bus.bottle_advance = 1'b0;
    endtask

    task automatic do_clr(input logic [11:0] tp, input logic [7:0] tb);
        clr = 1'b1;
        bus.enable = 1'b0;
        step();
        chk("reset", dut_outs(), 32'd0);
        clr = 1'b0;
        bus.target_pills   = tp;
        bus.target_bottles = tb;
        bus.enable         = 1'b1;
    endtask

    initial begin
        int ns, lt, first;
        clr = 1'b1;
        bus.pill_raw = 1'b0; bus.enable = 1'b0; bus.bottle_advance = 1'b0;
        bus.target_pills = 12'h003; bus.target_bottles = 8'h02;
        m_st = M_IDLE; m_p = 0; m_b = 0; m_t = 0; m_over = 0;

        // Basic two-bottle batch
        do_clr(12'h003, 8'h02);
        for (int k = 1; k <= 3; k++) begin
            pp();
            chk("t1_pills", bus.now_pills, bcd3(k));
        end
        chk("t1_full", bus.bottle_full, 1);
        chk("t1_bottles", bus.now_bottles, 8'h01);
        advance();
        chk("t1_adv_pills", bus.now_pills, 12'h000);
        repeat (3) pp();
        chk("t1_done", bus.batch_done, 1);
        chk("t1_bottles2", bus.now_bottles, 8'h02);
        advance();
        chk("t1_done_hold", {bus.batch_done, bus.bottle_full, bus.now_pills}, {2'b11, 12'h003});

        // Debounce: glitch rejected, valid pulse latency
        do_clr(12'h999, 8'h00);
        pill(D - 1, D + 2, 1'b0, ns, lt);
        chk("t2_glitch_strobes", ns, 0);
        chk("t2_glitch_pills", bus.now_pills, 12'h000);
        pill(D + 2, D + 2, 1'b0, ns, lt);
        chk("t2_strobe_count", ns, 1);
        chk("t2_strobe_latency", lt, D + 3);

        // BCD carry and saturation
        repeat (8) pp();
        chk("t3_nine", bus.now_pills, 12'h009);
        bus.target_pills = 12'h012;
        pp();
        chk("t3_carry", bus.now_pills, 12'h010);
        bus.target_pills = 12'h999;
        repeat (1000) pp();
        chk("t3_saturate", bus.now_pills, 12'h999);
        chk("t3_full", bus.bottle_full, 1);
        chk("t3_overfill", bus.overfill, OVF);

        // Starvation timer
        do_clr(12'h999, 8'h00);
        first = -1;
        for (int i = 1; i <= SMS + 5; i++) begin
            step();
            if (bus.starve && first < 0) first = i;
        end
        chk("t4_starve_at", first, SMS + 1);
        pp();
        chk("t4_starve_clr", bus.starve, 0);
        repeat (150) step();
        bus.enable = 1'b0;
        repeat (200) step();
        bus.enable = 1'b1;
        repeat (100) step();
        chk("t4_hold", bus.starve, 0);
        repeat (60) step();
        chk("t4_resume", bus.starve, 1);
        advance();
        chk("t4_adv_clr", bus.starve, 0);

        // Pill and advance together in FULL; overfill
        do_clr(12'h001, 8'h00);
        pp();
        chk("t5_full", bus.bottle_full, 1);
        pill(D + 2, D + 2, 1'b1, ns, lt);
        chk("t5_adv_pills", bus.now_pills, 12'h000);
        chk("t5_adv_full", bus.bottle_full, 0);
        chk("t5_adv_overfill", bus.overfill, 0);
        pp();
        chk("t5_refill_bottles", bus.now_bottles, 8'h02);
        pp();
        chk("t5_overfill", bus.overfill, OVF);

        // clr mid-fill, then restart
        do_clr(12'h999, 8'h00);
        repeat (5) pp();
        chk("t6_five", bus.now_pills, 12'h005);
        do_clr(12'h000, 8'h00);
        step();
        chk("t6_filling_not_full", bus.bottle_full, 0);
        step();
        chk("t6_full_next", bus.bottle_full, 1);

        // Randomised traffic
        for (int rnd = 0; rnd < 6; rnd++) begin
            do_clr(bcd3($urandom_range(0, 7)), bcd2($urandom_range(0, 3)));
            for (int it = 0; it < 40; it++) begin
                int r;
                r = $urandom_range(0, 9);
                if (r < 6) begin
                    pill($urandom_range(D - 2, D + 3), $urandom_range(D + 2, D + 5),
                         ($urandom_range(0, 3) == 0), ns, lt);
                end else if (r == 6) begin
                    bus.enable = ~bus.enable;
                    repeat ($urandom_range(1, 4)) step();
                end else if (r < 9) begin
                    advance();
                end else begin
                    repeat ($urandom_range(1, 5)) step();
                end
            end
            bus.enable = 1'b1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
